imem_loader: RTL

//  Writes a program into the instruction memory that the fetch stage reads. It receives a

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_byte.sv | 43 ++++
 rtl/imem_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM image loader: FSM state encoding,
// word/byte geometry and small decode helpers.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_FIN   = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // A word count of zero or beyond the IMEM budget is rejected.
    function automatic logic len_legal(input logic [31:0] n, input logic [31:0] max_words);
        return (n != 32'd0) && (n <= max_words);
    endfunction

    function automatic logic takes_bytes(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_byte.sv
// Byte-to-word packer shared by the length, data and checksum phases;
// first byte lands in the MSB after four takes.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic [7:0]         i_byte,
    input  logic               i_take,
    output logic [WORD_W-1:0]  o_word,
    output logic               o_word_done,
    output logic               o_last
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_done;

    // o_last flags the take that completes a word, so the owner can act on the same edge.
    assign o_last      = i_take && (r_cnt == LAST_CNT);
    assign o_word      = r_word;
    assign o_word_done = r_done;

    // Shift register, byte counter and word-complete pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= o_last;
            if (i_take) begin
                r_word <= {r_word[WORD_W-9:0], i_byte};
                r_cnt  <= o_last ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into IMEM and holds
// the core stalled until the image is fully written and verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_we,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_ready;
    logic               r_we;
    logic [31:0]        r_waddr;
    logic [31:0]        r_wdata;
    logic               r_hold;
    logic               r_done;
    logic               r_error;
    logic [IDX_W-1:0]   r_index;
    logic [IDX_W-1:0]   r_len;
    logic [31:0]        r_acc;

    logic               w_take;
    logic               w_start_load;
    logic [31:0]        w_word;
    logic [31:0]        w_full;
    logic               w_word_done;
    logic               w_last;
    logic               w_len_ok;
    logic               w_last_word;
    logic               w_write_exit;

    assign w_take       = i_byte_valid && r_ready;
    assign w_start_load = i_start && ((r_state == ST_IDLE) || (r_state == ST_FIN) || (r_state == ST_ERR));
    // Word including the byte being accepted this cycle.
    assign w_full       = {w_word[23:0], i_byte_in};
    assign w_len_ok     = len_legal(w_full, 32'(MAX_WORDS));
    assign w_last_word  = (r_index == (r_len - IDX_W'(1)));
    assign w_write_exit = (r_state == ST_WRITE) && w_word_done;

    imem_byte_packer u_packer (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (w_start_load),
        .i_byte      (i_byte_in),
        .i_take      (w_take),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_last      (w_last)
    );

    // Next-state decode for the load sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_LEN; else w_next = ST_IDLE;
            ST_LEN: begin
                if (w_last) w_next = w_len_ok ? ST_DATA : ST_ERR;
                else        w_next = ST_LEN;
            end
            ST_DATA:  if (w_last) w_next = ST_WRITE; else w_next = ST_DATA;
            ST_WRITE: w_next = w_last_word ? ST_CSUM : ST_DATA;
            ST_CSUM: begin
                if (w_last) w_next = (w_full == r_acc) ? ST_FIN : ST_ERR;
                else        w_next = ST_CSUM;
            end
            ST_FIN:   if (i_start) w_next = ST_LEN; else w_next = ST_FIN;
            ST_ERR:   if (i_start) w_next = ST_LEN; else w_next = ST_ERR;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register and outputs, all registered from the next state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= 32'd0;
            r_wdata <= 32'd0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= takes_bytes(w_next);
            r_we    <= (w_next == ST_WRITE);
            r_hold  <= (w_next != ST_FIN);
            r_done  <= (w_next == ST_FIN);
            r_error <= (w_next == ST_ERR);
            if (w_next == ST_WRITE) begin
                r_waddr <= BASE_ADDR + {{(32-IDX_W){1'b0}}, r_index};
                r_wdata <= w_full;
            end
        end
    end

    // Word count, write index and running checksum.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_index <= '0;
            r_len   <= '0;
            r_acc   <= 32'd0;
        end else begin
            if (w_start_load)      r_acc <= 32'd0;
            else if (w_write_exit) r_acc <= r_acc ^ w_word;
            if ((r_state == ST_LEN) && w_last && w_len_ok) begin
                r_len   <= w_full[IDX_W-1:0];
                r_index <= '0;
            end else if (w_write_exit) begin
                r_index <= r_index + IDX_W'(1);
            end
        end
    end

    assign o_byte_ready = r_ready;
    assign o_we         = r_we;
    assign o_waddr      = r_waddr;
    assign o_wdata      = r_wdata;
    assign o_cpu_hold   = r_hold;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule
